ccff_loader: RTL
================

CCFF_LOADER -- requirements
Module: ccff_loader

Interface
REQ-001 SHALL have parameter WORD_W, default 8, bits per bitstream word (>=1).
REQ-002 SHALL have parameter CHAIN_LEN, default 8, total configuration-chain length in bits (>=1).
REQ-003 SHALL have port prog_clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port prog_reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  begin a chain load; honoured only in IDLE.
REQ-006 SHALL have port wr_data  input  WORD_W  bitstream word, MSB shifted first.
REQ-007 SHALL have port wr_valid  input  1  wr_data valid.
REQ-008 SHALL have port wr_ready  output  1  loader accepts a word this cycle.
REQ-009 SHALL have port ccff_head  output  1  serial bit into the chain head.
REQ-010 SHALL have port ccff_tail  input  1  serial bit out of the chain tail.
REQ-011 SHALL have port shift_en  output  1  chain shifts on the prog_clk edge ending a cycle where shift_en=1.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port done  output  1  one-cycle pulse when the load completes.
REQ-014 SHALL have port rd_data  output  WORD_W  readback word captured from ccff_tail.
REQ-015 SHALL have port rd_valid  output  1  one-cycle pulse, rd_data valid.

Function
REQ-016 SHALL implement states IDLE, LOAD, SHIFT, DONE.
REQ-017 IDLE: wr_ready=0, shift_en=0; start=1 -> LOAD, bit counter cleared to 0; wr_valid ignored.
REQ-018 LOAD: wr_ready=1, shift_en=0; on wr_valid&wr_ready capture wr_data into shift register, set word-bit count n = min(WORD_W, CHAIN_LEN - counter), -> SHIFT.
REQ-019 SHIFT: shift_en=1 each cycle; ccff_head = shift register MSB (register-driven, no combinational path from inputs); on each edge shift register <<1, counter +1, n -1.
REQ-020 SHIFT: on each edge, sample ccff_tail into readback register MSB-first (first tail bit -> rd_data[WORD_W-1]).
REQ-021 SHIFT exit when n reaches 0: counter==CHAIN_LEN -> DONE, else -> LOAD.
REQ-022 Latency: word accepted at edge k -> shift_en high cycles k+1..k+n; minimum one idle (LOAD) cycle between consecutive words.
REQ-023 Partial last word: only the top n MSBs of wr_data are shifted; remaining bits discarded.
REQ-024 rd_valid SHALL pulse the cycle after a readback word completes (WORD_W bits or chain end); partial readback word left-justified, low bits zero.
REQ-025 DONE: done=1 for exactly one cycle, -> IDLE.
REQ-026 start asserted while busy SHALL be ignored; no restart, no error.
REQ-027 Counter width SHALL be clog2(CHAIN_LEN+1); no wrap possible within one load.
REQ-028 shift_en SHALL never be high outside SHIFT; total shift_en cycles per load exactly CHAIN_LEN.

Reset
REQ-029 prog_reset=1 SHALL immediately force IDLE, counter=0, shift register=0, ccff_head=0, shift_en=0, wr_ready=0, busy=0, done=0, rd_valid=0, rd_data=0.
REQ-030 Reset mid-load SHALL abort without further shifting; chain contents then undefined; next start begins a fresh load.

Verification
REQ-031 CHAIN_LEN=8, WORD_W=8, start, word 0xA5 -> shift_en 8 consecutive cycles, ccff_head 1,0,1,0,0,1,0,1, done pulse next cycle, busy low after.
REQ-032 Chain model preloaded by load of 0xA5, then load 0x00 -> rd_data=0xA5 with rd_valid one pulse; model chain holds 0x00.
REQ-033 CHAIN_LEN=11, WORD_W=8, words 0xFF,0xE0 -> 11 shift_en cycles total (8+3), second word bits 1,1,1 shifted, rd_valid pulses twice, second rd_data low 5 bits zero.
REQ-034 wr_valid held low in LOAD for 5 cycles -> shift_en stays 0, ccff_head stable, wr_ready stays 1; resumes on wr_valid.
REQ-035 start re-pulsed during SHIFT -> ignored, exactly CHAIN_LEN shifts, single done pulse.
REQ-036 prog_reset asserted on 4th SHIFT cycle -> shift_en/busy drop same cycle; after release, start + 0x3C completes normally with 8 shifts.

Source files
------------

// File: rtl/ccff_loader_if.sv
// Bus between a configuration-chain loader and the logic around it:
// the bitstream word handshake, the serial chain pins, and the status
// and readback outputs.
interface ccff_loader_if #(
  parameter int WORD_W = 8
) ();
  logic              start;
  logic [WORD_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;
  logic              ccff_head;
  logic              ccff_tail;
  logic              shift_en;
  logic              busy;
  logic              done;
  logic [WORD_W-1:0] rd_data;
  logic              rd_valid;

  // Controller side: supplies words, owns the chain tail.
  modport master (
    output start, wr_data, wr_valid, ccff_tail,
    input  wr_ready, ccff_head, shift_en, busy, done, rd_data, rd_valid
  );

  // Loader side.
  modport slave (
    input  start, wr_data, wr_valid, ccff_tail,
    output wr_ready, ccff_head, shift_en, busy, done, rd_data, rd_valid
  );
endinterface

// File: rtl/ccff_loader.sv
// Configuration-chain loader: takes bitstream words, shifts them MSB-first
// into a serial chain of CHAIN_LEN bits, and returns the bits falling out
// of the chain tail as left-justified readback words.
module ccff_loader #(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 8
) (
  input logic         prog_clk,
  input logic         prog_reset,
  ccff_loader_if.slave bus
);
  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int N_W   = $clog2(WORD_W + 1);
  localparam int POS_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt;
  logic [N_W-1:0]    n_left;
  logic [N_W-1:0]    n_load;
  logic [31:0]       remain;
  logic [WORD_W-1:0] sreg;
  logic [WORD_W-1:0] rb;
  logic [WORD_W-1:0] rb_next;
  logic [POS_W-1:0]  rb_pos;
  logic [WORD_W-1:0] rd_data_q;
  logic              rd_valid_q;
  logic              last_bit;
  logic              chain_end;
  logic              wr_ready_c;
  logic              shift_en_c;
  logic              busy_c;
  logic              done_c;

  assign last_bit  = (n_left == N_W'(1));
  assign chain_end = (cnt == CNT_W'(CHAIN_LEN - 1));

  // Bits to take from the next word: a full word, or whatever the chain still needs.
  always_comb begin
    remain = 32'(CHAIN_LEN) - 32'(cnt);
    n_load = (remain > 32'(WORD_W)) ? N_W'(WORD_W) : N_W'(remain);
  end

  // Readback word including the tail bit sampled on this edge.
  always_comb begin
    rb_next         = rb;
    rb_next[rb_pos] = bus.ccff_tail;
  end

  // State register.
  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) state <= IDLE;
    else            state <= state_next;
  end

  // Next-state and handshake/status decode.
  always_comb begin
    state_next = state;
    wr_ready_c = 1'b0;
    shift_en_c = 1'b0;
    busy_c     = 1'b1;
    done_c     = 1'b0;
    case (state)
      IDLE: begin
        busy_c = 1'b0;
        if (bus.start) state_next = LOAD;
      end
      LOAD: begin
        wr_ready_c = 1'b1;
        if (bus.wr_valid) state_next = SHIFT;
      end
      SHIFT: begin
        shift_en_c = 1'b1;
        if (last_bit) state_next = chain_end ? DONE : LOAD;
      end
      DONE: begin
        done_c     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Shift/readback datapath; readback words share the write-word boundaries.
  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      cnt        <= '0;
      n_left     <= '0;
      sreg       <= '0;
      rb         <= '0;
      rb_pos     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) cnt <= '0;
        end
        LOAD: begin
          if (bus.wr_valid) begin
            sreg   <= bus.wr_data;
            n_left <= n_load;
            rb     <= '0;
            rb_pos <= POS_W'(WORD_W - 1);
          end
        end
        SHIFT: begin
          sreg   <= sreg << 1;
          cnt    <= cnt + 1'b1;
          n_left <= n_left - 1'b1;
          rb     <= rb_next;
          rb_pos <= rb_pos - 1'b1;
          if (last_bit) begin
            rd_data_q  <= rb_next;
            rd_valid_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.wr_ready  = wr_ready_c;
  assign bus.shift_en  = shift_en_c;
  assign bus.busy      = busy_c;
  assign bus.done      = done_c;
  assign bus.ccff_head = sreg[WORD_W-1];
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;
endmodule
